// File: rtl/bf_pkg.sv
// bf_pkg: shared state encoding and default parameters for the boot controller
package bf_pkg;
    localparam int addr_size_default    = 9;
    localparam int idle_timeout_default = 1000;
    typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;
endpackage

// File: rtl/boot_ctrl_idle_timer.sv
// idle_timer: saturating idle counter; done flags the edge on which it reaches the limit
module idle_timer #(
    parameter int limit = 1000,
    localparam int cw = $clog2(limit + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);
    logic [cw-1:0] cnt;
    always_ff @(posedge clk)
        if (reset || clear) cnt <= '0;
        else if (enable && cnt != cw'(limit)) cnt <= cnt + 1'b1;
    // done fires one edge early so the exit edge is the one that completes the count
    assign done = enable && ({1'b0, cnt} + 1'b1 >= (cw + 1)'(limit));
endmodule

// File: rtl/boot_ctrl.sv
// boot_ctrl: sequences program load, zero-fill of the RAM tail and CPU release
module boot_ctrl
    import bf_pkg::*;
#(
    parameter int addrSize    = addr_size_default,
    parameter int idleTimeout = idle_timeout_default
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_req,
    input  logic                new_data,
    input  logic                ld_write_rq,
    input  logic [addrSize-1:0] ld_addr,
    input  logic [7:0]          ld_data,
    input  logic [addrSize-1:0] cpu_addr,
    output logic                ram_we,
    output logic [addrSize-1:0] ram_addr,
    output logic [7:0]          ram_wdata,
    output logic                loader_reset,
    output logic                cpu_reset,
    output logic                busy
);
    state_t state, state_nx;
    logic seen, seen_nx, timeout;
    logic [addrSize-1:0] ptr, ptr_nx;
    idle_timer #(.limit(idleTimeout)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(state != LOAD || new_data),
        .enable(state == LOAD && seen && !new_data),
        .done(timeout)
    );
    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            seen  <= 1'b0;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            seen  <= seen_nx;
            ptr   <= ptr_nx;
        end
    always_comb begin
        state_nx     = state;
        seen_nx      = 1'b0;
        ptr_nx       = ptr;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        loader_reset = 1'b1;
        cpu_reset    = 1'b1;
        case (state)
            IDLE: state_nx = load_req ? LOAD : IDLE;
            LOAD: begin
                loader_reset = 1'b0;
                ram_we       = ld_write_rq;
                ram_addr     = ld_addr;
                ram_wdata    = ld_data;
                seen_nx      = seen | new_data;
                ptr_nx       = ld_addr;
                state_nx     = (seen && timeout) ? FILL : LOAD;
            end
            FILL: begin
                ram_we   = 1'b1;
                ram_addr = ptr;
                ptr_nx   = ptr + 1'b1;
                state_nx = (&ptr) ? RUN : FILL;
            end
            RUN: begin
                cpu_reset = 1'b0;
                ram_addr  = cpu_addr;
                state_nx  = load_req ? LOAD : RUN;
            end
            default: state_nx = IDLE;
        endcase
        // reset overrides the current state so nothing leaks out before the state register clears
        if (reset) begin
            ram_we       = 1'b0;
            ram_addr     = '0;
            ram_wdata    = '0;
            loader_reset = 1'b1;
            cpu_reset    = 1'b1;
        end
        busy = reset || state != RUN;
    end
endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 Parameter: addrSize, 9, program RAM address width.
REQ-002 Parameter: idleTimeout, 1000, idle clk cycles after the last byte that end a load.
REQ-003 Port: clk  input  1  clock, all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: load_req  input  1  request a new program load (level, sampled each cycle).
REQ-006 Port: new_data  input  1  byte strobe from the serial front end, same signal that feeds the loader.
REQ-007 Port: ld_write_rq  input  1  loader write request.
REQ-008 Port: ld_addr  input  addrSize  loader address, equals bytes written so far.
REQ-009 Port: ld_data  input  8  loader write data.
REQ-010 Port: cpu_addr  input  addrSize  CPU instruction fetch address.
REQ-011 Port: ram_we  output  1  program RAM write enable.
REQ-012 Port: ram_addr  output  addrSize  program RAM address.
REQ-013 Port: ram_wdata  output  8  program RAM write data.
REQ-014 Port: loader_reset  output  1  reset to the loader.
REQ-015 Port: cpu_reset  output  1  reset to the CPU core.
REQ-016 Port: busy  output  1  high in every state except RUN.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, FILL, RUN; one state register, transitions on clk only.
REQ-018 IDLE: loader_reset=1, cpu_reset=1, ram_we=0; next state LOAD when load_req=1, else IDLE.
REQ-019 LOAD: loader_reset=0, cpu_reset=1; ram_we=ld_write_rq, ram_addr=ld_addr, ram_wdata=ld_data, all combinational passthrough.
REQ-020 LOAD idle counter (width ceil(log2(idleTimeout+1))): cleared on new_data=1, else increments, saturating at idleTimeout; counts only after the first new_data of this load (seen flag).
REQ-021 LOAD exit: counter reaches idleTimeout with seen=1 -> FILL; registered fill pointer loaded with ld_addr on the same edge.
REQ-022 LOAD with no byte ever received SHALL stay in LOAD indefinitely.
REQ-023 FILL: loader_reset=1, cpu_reset=1, ram_we=1, ram_addr=fill pointer, ram_wdata=8'h00; pointer +1 per cycle.
REQ-024 FILL ends after writing address 2^addrSize-1 -> RUN next cycle; if ld_addr=0 at entry (RAM full, wrapped) FILL SHALL write all 2^addrSize locations.
REQ-025 RUN: loader_reset=1, cpu_reset=0, ram_we=0, ram_addr=cpu_addr, busy=0.
REQ-026 RUN with load_req=1 -> LOAD on next edge; cpu_reset and loader_reset change in that same cycle, no RUN/LOAD overlap.
REQ-027 load_req during LOAD or FILL SHALL be ignored.
REQ-028 ram_we SHALL never be 1 in IDLE or RUN.
REQ-029 Counter and pointer arithmetic modulo field width; no other wrap behaviour.

Reset
REQ-030 reset=1 SHALL force IDLE, counter=0, seen=0, fill pointer=0 on the next edge, from any state including mid-FILL.
REQ-031 During and right after reset: ram_we=0, ram_addr=0, ram_wdata=0, loader_reset=1, cpu_reset=1, busy=1.

Structure
REQ-032 State encodings SHALL sit in shared package bf_pkg with default addrSize and idleTimeout constants.
REQ-033 Idle timeout counter SHALL be a sub-module idle_timer (clear, enable, done); rest is flat.

Verification
REQ-034 Reset then load_req=1 one cycle -> state LOAD, loader_reset=0, cpu_reset=1, busy=1.
REQ-035 addrSize=4, idleTimeout=8: load 3 bytes 0x2B,0x2E,0x5B -> RAM[0..2] written, 8 idle cycles, FILL writes 0x00 to 3..15 (13 cycles), then RUN, cpu_reset=0.
REQ-036 addrSize=4: load 16 bytes -> ld_addr wraps to 0, FILL writes 16 zeros, RUN reached.
REQ-037 Bytes spaced 7 cycles apart, idleTimeout=8 -> stays in LOAD until 8 idle cycles after last byte.
REQ-038 reset asserted at third FILL cycle -> IDLE next edge, ram_we=0, no further RAM writes.
REQ-039 In RUN, cpu_addr=5 -> ram_addr=5, ram_we=0; load_req=1 -> LOAD, cpu_reset=1 same edge.
